// File: rtl/eq_band_scheduler.sv
// Per-sample equalizer gain stage: on each sample strobe, reads every band through
// one shared multiplier, accumulates the gain-weighted bands, then saturates and
// emits one output sample. Also holds the shadow/active gain register file.
module eq_band_scheduler #(
  parameter int unsigned NumBands    = 10,
  parameter int unsigned DataW       = 24,
  parameter int unsigned GainW       = 8,
  parameter int unsigned GainFrac    = 4,
  parameter int unsigned DefaultGain = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_valid_i,
  input  logic             cfg_we_i,
  input  logic [3:0]       cfg_addr_i,
  input  logic [GainW-1:0] cfg_wdata_i,
  output logic [GainW-1:0] cfg_rdata_o,
  output logic             band_req_o,
  output logic [3:0]       band_idx_o,
  input  logic             band_ack_i,
  input  logic [DataW-1:0] band_data_i,
  output logic [DataW-1:0] audio_out_o,
  output logic             audio_out_valid_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int unsigned ProdW = DataW + GainW + 1;
  // Headroom for summing up to 16 products.
  localparam int unsigned AccW  = ProdW + 4;
  localparam logic [3:0]  LastIdx = 4'(NumBands - 1);
  localparam logic signed [AccW-1:0] SatMax = AccW'((64'sd1 <<< (DataW - 1)) - 64'sd1);
  localparam logic signed [AccW-1:0] SatMin = AccW'(-(64'sd1 <<< (DataW - 1)));

  typedef enum logic [1:0] {StIdle, StReq, StOut} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              band_idx_q, band_idx_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [DataW-1:0]        audio_q, audio_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic [GainW-1:0]        gain_shadow_q [NumBands];
  logic [GainW-1:0]        gain_shadow_d [NumBands];
  logic [GainW-1:0]        gain_active_q [NumBands];
  logic [GainW-1:0]        gain_active_d [NumBands];

  logic [GainW-1:0]        gain_sel;
  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  shifted;
  logic [DataW-1:0]        sat_val;

  // Select the active gain of the band being read.
  always_comb begin
    gain_sel = '0;
    for (int unsigned i = 0; i < NumBands; i++) begin
      if (band_idx_q == 4'(i)) gain_sel = gain_active_q[i];
    end
  end

  // Shadow gain read-back; unmapped addresses read as zero.
  always_comb begin
    cfg_rdata_o = '0;
    for (int unsigned i = 0; i < NumBands; i++) begin
      if (cfg_addr_i == 4'(i)) cfg_rdata_o = gain_shadow_q[i];
    end
  end

  // Signed sample times zero-extended gain, then floor-shift and saturate.
  always_comb begin
    prod    = $signed(band_data_i) * $signed({1'b0, gain_sel});
    shifted = acc_q >>> GainFrac;
    if (shifted > SatMax) begin
      sat_val = {1'b0, {(DataW - 1){1'b1}}};
    end else if (shifted < SatMin) begin
      sat_val = {1'b1, {(DataW - 1){1'b0}}};
    end else begin
      sat_val = shifted[DataW-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sample_valid_i) state_d = StReq;
      StReq:   if (band_ack_i && (band_idx_q == LastIdx)) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    band_req_o        = (state_q == StReq);
    busy_o            = (state_q != StIdle);
    band_idx_o        = band_idx_q;
    audio_out_o       = audio_q;
    audio_out_valid_o = valid_q;
    overrun_o         = overrun_q;
  end

  // Datapath next-state: gain commit, accumulation, output load.
  always_comb begin
    band_idx_d    = band_idx_q;
    acc_d         = acc_q;
    audio_d       = audio_q;
    valid_d       = 1'b0;
    overrun_d     = sample_valid_i && (state_q != StIdle);
    gain_active_d = gain_active_q;
    gain_shadow_d = gain_shadow_q;
    for (int unsigned i = 0; i < NumBands; i++) begin
      if (cfg_we_i && (cfg_addr_i == 4'(i))) gain_shadow_d[i] = cfg_wdata_i;
    end
    unique case (state_q)
      StIdle: begin
        if (sample_valid_i) begin
          // Commit uses the pre-write shadow, so a same-edge write lands next sample.
          gain_active_d = gain_shadow_q;
          acc_d         = '0;
          band_idx_d    = '0;
        end
      end
      StReq: begin
        if (band_ack_i) begin
          acc_d = acc_q + {{(AccW - ProdW){prod[ProdW-1]}}, prod};
          if (band_idx_q != LastIdx) band_idx_d = band_idx_q + 4'd1;
        end
      end
      StOut: begin
        audio_d    = sat_val;
        valid_d    = 1'b1;
        band_idx_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      band_idx_q <= '0;
      acc_q      <= '0;
      audio_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      for (int unsigned i = 0; i < NumBands; i++) begin
        gain_shadow_q[i] <= GainW'(DefaultGain);
        gain_active_q[i] <= GainW'(DefaultGain);
      end
    end else begin
      band_idx_q    <= band_idx_d;
      acc_q         <= acc_d;
      audio_q       <= audio_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      gain_shadow_q <= gain_shadow_d;
      gain_active_q <= gain_active_d;
    end
  end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed bench for eq_band_scheduler: reset, gains, saturation, stalls, overrun, commit.
module tb_eq_band_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [7:0]  cfg_rdata;
  logic        band_req;
  logic [3:0]  band_idx;
  logic        band_ack;
  logic [23:0] band_data;
  logic [23:0] audio_out;
  logic        audio_out_valid;
  logic        busy;
  logic        overrun;

  logic [23:0] band_mem [16];
  assign band_data = band_mem[band_idx];

  always #5 clk = ~clk;

  eq_band_scheduler dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .sample_valid_i   (sample_valid),
    .cfg_we_i         (cfg_we),
    .cfg_addr_i       (cfg_addr),
    .cfg_wdata_i      (cfg_wdata),
    .cfg_rdata_o      (cfg_rdata),
    .band_req_o       (band_req),
    .band_idx_o       (band_idx),
    .band_ack_i       (band_ack),
    .band_data_i      (band_data),
    .audio_out_o      (audio_out),
    .audio_out_valid_o(audio_out_valid),
    .busy_o           (busy),
    .overrun_o        (overrun)
  );

  int          errors = 0;
  int          checks = 0;
  int          lat_r, ovr_cnt, ovr_at, nreads;
  int          reads [16];
  logic [23:0] out_r;
  bit          stable_ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_all_gains(input logic [7:0] g);
    for (int i = 0; i < 10; i++) cfg_write(4'(i), g);
  endtask

  task automatic set_all_data(input logic [23:0] d);
    for (int i = 0; i < 16; i++) band_mem[i] = d;
  endtask

  // Strobe one sample (loop index n = edge number relative to the strobe edge) and
  // wait for the output pulse; optionally re-strobe and write a gain at given edges.
  task automatic run_sample(input int period, input int sv2_at, input int wr_at,
                            input logic [3:0] wr_addr, input logic [7:0] wr_data);
    logic       prev_req, prev_ack;
    logic [3:0] prev_idx;
    lat_r = -1; ovr_cnt = 0; ovr_at = -1; nreads = 0; stable_ok = 1'b1; out_r = '0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_idx = '0;
    for (int n = 0; n < 200; n++) begin
      sample_valid = (n == 0) || (n == sv2_at);
      band_ack     = (n % period == 0);
      cfg_we       = (n == wr_at);
      cfg_addr     = wr_addr;
      cfg_wdata    = wr_data;
      if (prev_req && !prev_ack && (band_req !== 1'b1 || band_idx !== prev_idx)) stable_ok = 0;
      if (band_req && band_ack) begin
        if (nreads < 16) reads[nreads] = int'(band_idx);
        nreads++;
      end
      prev_req = band_req; prev_ack = band_ack; prev_idx = band_idx;
      tick();
      sample_valid = 1'b0;
      cfg_we       = 1'b0;
      if (overrun) begin ovr_cnt++; ovr_at = n; end
      if (audio_out_valid) begin lat_r = n; out_r = audio_out; break; end
    end
    band_ack = 1'b1;
  endtask

  function automatic bit order_ok();
    bit ok = (nreads == 10);
    for (int i = 0; i < 10; i++) if (reads[i] != i) ok = 1'b0;
    return ok;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; sample_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    band_ack = 1'b1;
    set_all_data(24'd0);
    #22;
    checks++; if (audio_out !== 24'd0) begin errors++; $display("FAIL reset_audio: got %h want 000000", audio_out); end
    checks++; if (audio_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", audio_out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (band_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", band_req); end
    checks++; if (band_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", band_idx); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    cfg_addr = 4'd0; #1;
    checks++; if (cfg_rdata !== 8'd16) begin errors++; $display("FAIL reset_gain0: got %0d want 16", cfg_rdata); end
    cfg_addr = 4'd9; #1;
    checks++; if (cfg_rdata !== 8'd16) begin errors++; $display("FAIL reset_gain9: got %0d want 16", cfg_rdata); end
    cfg_addr = 4'd10; #1;
    checks++; if (cfg_rdata !== 8'd0) begin errors++; $display("FAIL reset_gain10: got %0d want 0", cfg_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_all_data(24'd1000);
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'd10000) begin errors++; $display("FAIL basic_out: got %0d want 10000", out_r); end
    checks++; if (lat_r !== 11) begin errors++; $display("FAIL basic_latency: got %0d want 11", lat_r); end
    checks++; if (!order_ok()) begin errors++; $display("FAIL basic_order: reads=%0d want 10 in order", nreads); end
    tick();
    checks++; if (audio_out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: got %b want 0", audio_out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    checks++; if (audio_out !== 24'd10000) begin errors++; $display("FAIL basic_hold: got %0d want 10000", audio_out); end
  endtask

  task automatic test_cfg();
    for (int i = 0; i < 10; i++) cfg_write(4'(i), (i < 3) ? 8'd16 : 8'd0);
    cfg_write(4'd12, 8'h55);
    cfg_addr = 4'd2; #1;
    checks++; if (cfg_rdata !== 8'd16) begin errors++; $display("FAIL cfg_rd2: got %0d want 16", cfg_rdata); end
    cfg_addr = 4'd3; #1;
    checks++; if (cfg_rdata !== 8'd0) begin errors++; $display("FAIL cfg_rd3: got %0d want 0", cfg_rdata); end
    cfg_addr = 4'd12; #1;
    checks++; if (cfg_rdata !== 8'd0) begin errors++; $display("FAIL cfg_rd12: got %0d want 0", cfg_rdata); end
    cfg_addr = 4'd4; #1;
    checks++; if (cfg_rdata !== 8'd0) begin errors++; $display("FAIL cfg_rd4_alias: got %0d want 0", cfg_rdata); end
    set_all_data(24'd100);
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'd300) begin errors++; $display("FAIL cfg_out: got %0d want 300", out_r); end
  endtask

  task automatic test_saturation();
    set_all_gains(8'd255);
    set_all_data(24'h7FFFFF);
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'h7FFFFF) begin errors++; $display("FAIL sat_pos: got %h want 7fffff", out_r); end
    set_all_data(24'h800000);
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'h800000) begin errors++; $display("FAIL sat_neg: got %h want 800000", out_r); end
    cfg_write(4'd0, 8'd8);
    for (int i = 1; i < 10; i++) cfg_write(4'(i), 8'd0);
    set_all_data(24'h7FFFFF);
    band_mem[0] = 24'd3;
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'd1) begin errors++; $display("FAIL frac_pos: got %h want 000001", out_r); end
    checks++; if (nreads !== 10) begin errors++; $display("FAIL zero_gain_reads: got %0d want 10", nreads); end
    band_mem[0] = 24'hFFFFFD;
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'hFFFFFE) begin errors++; $display("FAIL frac_neg_floor: got %h want fffffe", out_r); end
  endtask

  task automatic test_stall();
    set_all_gains(8'd16);
    for (int i = 0; i < 16; i++) band_mem[i] = 24'((i + 1) * 160);
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'd8800) begin errors++; $display("FAIL nostall_out: got %0d want 8800", out_r); end
    run_sample(4, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'd8800) begin errors++; $display("FAIL stall_out: got %0d want 8800", out_r); end
    checks++; if (lat_r !== 41) begin errors++; $display("FAIL stall_latency: got %0d want 41", lat_r); end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b want 1", stable_ok); end
    checks++; if (!order_ok()) begin errors++; $display("FAIL stall_order: reads=%0d want 10 in order", nreads); end
  endtask

  task automatic test_overrun();
    set_all_data(24'd1000);
    run_sample(1, 5, -1, 4'd0, 8'd0);
    checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt); end
    checks++; if (ovr_at !== 5) begin errors++; $display("FAIL ovr_edge: got %0d want 5", ovr_at); end
    checks++; if (out_r !== 24'd10000) begin errors++; $display("FAIL ovr_out: got %0d want 10000", out_r); end
    checks++; if (lat_r !== 11) begin errors++; $display("FAIL ovr_latency: got %0d want 11", lat_r); end
    tick();
    checks++; if (audio_out_valid !== 1'b0) begin errors++; $display("FAIL ovr_single_pulse: got %b want 0", audio_out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_no_restart: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    set_all_data(24'd1000);
    run_sample(1, -1, -1, 4'd0, 8'd0);
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (lat_r !== 11) begin errors++; $display("FAIL b2b_latency: got %0d want 11", lat_r); end
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL b2b_overrun: got %0d want 0", ovr_cnt); end
    checks++; if (out_r !== 24'd10000) begin errors++; $display("FAIL b2b_out: got %0d want 10000", out_r); end
  endtask

  task automatic test_commit();
    set_all_data(24'd100);
    run_sample(1, -1, 3, 4'd0, 8'd0);
    checks++; if (out_r !== 24'd1000) begin errors++; $display("FAIL commit_midwrite: got %0d want 1000", out_r); end
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'd900) begin errors++; $display("FAIL commit_next: got %0d want 900", out_r); end
    run_sample(1, -1, 0, 4'd0, 8'd16);
    checks++; if (out_r !== 24'd900) begin errors++; $display("FAIL commit_same_edge: got %0d want 900", out_r); end
    run_sample(1, -1, -1, 4'd0, 8'd0);
    checks++; if (out_r !== 24'd1000) begin errors++; $display("FAIL commit_after: got %0d want 1000", out_r); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    set_all_data(24'd1000);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (audio_out !== 24'd0) begin errors++; $display("FAIL midrst_audio: got %0d want 0", audio_out); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (audio_out_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg();
    test_saturation();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_commit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/eq_band_scheduler.md
Name: eq_band_scheduler

Overview:
- Per-sample sequencer and gain stage for the 10-band equalizer, placed between the band filter bank and the top-level audio_out.
- On each audio sample strobe it reads every band output through one shared multiplier and weights it by that band's gain.
- It accumulates the weighted bands, saturates the sum and emits one 24-bit output sample.
- Holds the band gain register file written by the I2C register interface (addresses 0x00..0x09); gains are committed only at sample boundaries.

Parameters:
- NUM_BANDS, 10, number of equalizer bands / gain registers.
- DATA_W, 24, signed audio sample width.
- GAIN_W, 8, unsigned gain width.
- GAIN_FRAC, 4, gain fractional bits; 16 = unity.
- DEFAULT_GAIN, 16, reset value of every gain register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- sample_valid  in  1  one-cycle strobe: new audio sample available at the filter bank
- cfg_we  in  1  gain register write enable from I2C register interface
- cfg_addr  in  4  gain register address
- cfg_wdata  in  8  gain write data
- cfg_rdata  out  8  shadow gain at cfg_addr (combinational read-back); 0 for addr >= NUM_BANDS
- band_req  out  1  request for band output band_idx
- band_idx  out  4  band being read
- band_ack  in  1  filter bank: band_data valid this cycle
- band_data  in  24  signed band output
- audio_out  out  24  signed equalized sample; held between updates
- audio_out_valid  out  1  one-cycle pulse when audio_out updates
- busy  out  1  high in any state other than IDLE
- overrun  out  1  one-cycle pulse when sample_valid is dropped

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). Reset values:
  - state IDLE
  - band_req 0, band_idx 0
  - audio_out 0, audio_out_valid 0
  - busy 0, overrun 0
  - accumulator 0
  - shadow and active gains all DEFAULT_GAIN
- Reset mid-sequence: abandons the sample; no output pulse.
- Config:
  - cfg_we with cfg_addr < NUM_BANDS writes the shadow gain on that edge.
  - cfg_addr >= NUM_BANDS: write ignored.
  - Writes are accepted in any state.
- States:
  - IDLE: on sample_valid, copy all shadow gains to active gains, clear the accumulator, set band_idx 0, band_req 1, go to REQ.
  - REQ: band_req high and band_idx stable until band_ack.
    - On a cycle with band_req && band_ack: acc += band_data * {0,gain_active[band_idx]}. band_data is signed, the gain is zero-extended, the product is 33-bit signed and the accumulator is 37-bit signed.
    - If band_idx == NUM_BANDS-1: band_req 0, go to OUT. Otherwise band_idx+1 and band_req stays high.
    - band_ack while band_req is low is ignored.
  - OUT: result = acc >>> GAIN_FRAC (arithmetic shift, floor). Saturate to [-8388608, 8388607] (0x800000..0x7FFFFF). Load audio_out, pulse audio_out_valid for 1 cycle, go to IDLE.
- Gains of 0 still request the band; every band is read each sample.
- Latency with band_ack tied high:
  - sample_valid sampled at edge 0.
  - Accumulate on edges 1..NUM_BANDS.
  - audio_out/audio_out_valid registered at edge NUM_BANDS+1 (11).
  - Next sample_valid is accepted from edge NUM_BANDS+2.
  - Each stall cycle of band_ack adds one clock.
- Boundary conditions:
  - sample_valid while busy: sample dropped, overrun pulses 1 cycle, current computation unaffected.
  - cfg write on the same edge as commit: active gets the previous shadow value; the new value applies from the next sample.
  - Writes during REQ/OUT never affect the sample in progress.
  - audio_out holds its last value until the next OUT.

Test Plan:
- Reset, all band_data = 1000, band_ack tied 1, one sample_valid -> audio_out = 10000, audio_out_valid one pulse exactly 11 clocks after the strobe edge, busy low afterwards.
- Write gains 16,16,16,0,0,0,0,0,0,0; band_data = 100 for all bands; next sample -> audio_out = 300. Read back addr 2 -> 16, addr 3 -> 0, addr 12 -> 0, and a write to addr 12 has no effect.
- All gains 255, all band_data 0x7FFFFF -> audio_out 0x7FFFFF. All band_data 0x800000 -> 0x800000. Band 0 only at gain 8, band_data 3 -> audio_out 1; band_data -3 -> audio_out 0xFFFFFE (floor).
- band_ack asserted only every 4th cycle -> band_idx and band_req stable while waiting, each band read once in order 0..9, same result as the no-stall run, output at edge 10*4+1.
- Two sample_valid strobes 5 clocks apart -> overrun pulses once at the second strobe, exactly one audio_out_valid, result from the first sample.
- Write gain 0 to band 0 at edge 3 of a sample (all gains 16, band_data 100) -> that sample = 1000, next sample = 900. A write on the commit edge takes effect one sample later.
